// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID register block: register map, CAPS layout
// and CONTROL bit positions.
package sysid_pkg;

    localparam logic [3:0] SYSID_ADDR_ID        = 4'd0;
    localparam logic [3:0] SYSID_ADDR_TIMESTAMP = 4'd1;
    localparam logic [3:0] SYSID_ADDR_UPTIME_LO = 4'd2;
    localparam logic [3:0] SYSID_ADDR_UPTIME_HI = 4'd3;
    localparam logic [3:0] SYSID_ADDR_SCRATCH   = 4'd4;
    localparam logic [3:0] SYSID_ADDR_CONTROL   = 4'd5;
    localparam logic [3:0] SYSID_ADDR_CAPS      = 4'd6;
    localparam logic [3:0] SYSID_ADDR_RSVD      = 4'd7;
    localparam logic [3:0] SYSID_ADDR_USER0     = 4'd8;

    localparam logic [15:0] SYSID_CAPS_VERSION = 16'h0002;

    localparam int unsigned SYSID_CAPS_NUM_USER_LSB = 0;
    localparam int unsigned SYSID_CAPS_UPTIME_BIT   = 8;
    localparam int unsigned SYSID_CAPS_VERSION_LSB  = 16;

    localparam int unsigned SYSID_CTRL_CLEAR_BIT = 0;

    function automatic logic [31:0] sysid_caps(input int unsigned num_user, input logic uptime);
        logic [31:0] caps;
        logic [3:0]  nu;
        nu = num_user[3:0];
        caps = '0;
        caps[SYSID_CAPS_NUM_USER_LSB +: 4]   = nu;
        caps[SYSID_CAPS_UPTIME_BIT]          = uptime;
        caps[SYSID_CAPS_VERSION_LSB +: 16]   = SYSID_CAPS_VERSION;
        return caps;
    endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Free-running 64-bit uptime counter with synchronous clear and a HI-word shadow
// captured whenever software samples the LO word.
module sysid_uptime_ctr (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture,
    output logic [31:0] count_lo,
    output logic [31:0] hi_shadow
);

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q;

    // Wraps silently at 2^64-1.
    always_comb begin
        cnt_d = cnt_q + 64'd1;
        if (clear) begin
            cnt_d = '0;
        end
    end

    // Shadow takes the pre-clear HI so a LO read racing a clear stays coherent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (capture) begin
                shadow_q <= cnt_q[63:32];
            end
        end
    end

    assign count_lo  = cnt_q[31:0];
    assign hi_shadow = shadow_q;

endmodule

// File: rtl/sysid_regs_ext.sv
// Avalon-MM system-ID register block. Define SYSID_UPTIME_EN to build in the
// 64-bit uptime counter; otherwise the uptime words read 0 and CONTROL is inert.
module sysid_regs_ext
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
    parameter int unsigned NUM_USER  = 2,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [255:0]      user_words,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    logic [31:0] up_lo;
    logic [31:0] up_hi;

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;

    logic up_clear;
    logic up_capture;

    assign up_clear   = write && (address == SYSID_ADDR_CONTROL)
                        && writedata[SYSID_CTRL_CLEAR_BIT];
    assign up_capture = read && (address == SYSID_ADDR_UPTIME_LO);

    sysid_uptime_ctr u_uptime (
        .clock     (clock),
        .reset     (reset),
        .clear     (up_clear),
        .capture   (up_capture),
        .count_lo  (up_lo),
        .hi_shadow (up_hi)
    );
`else
    localparam logic UPTIME_PRESENT = 1'b0;

    assign up_lo = '0;
    assign up_hi = '0;
`endif

    localparam logic [31:0] CAPS_WORD = sysid_caps(NUM_USER, UPTIME_PRESENT);

    logic [31:0] scratch_q;
    logic [31:0] readdata_q;
    logic        rvalid_q;
    logic [31:0] rd_data;
    logic [2:0]  user_idx;
    logic        scratch_we;

    assign user_idx   = address[2:0];
    assign scratch_we = write && (address == SYSID_ADDR_SCRATCH);

    always_comb begin
        rd_data = '0;
        case (address)
            SYSID_ADDR_ID:        rd_data = SYSTEM_ID;
            SYSID_ADDR_TIMESTAMP: rd_data = TIMESTAMP;
            SYSID_ADDR_UPTIME_LO: rd_data = up_lo;
            SYSID_ADDR_UPTIME_HI: rd_data = up_hi;
            SYSID_ADDR_SCRATCH:   rd_data = scratch_q;
            SYSID_ADDR_CAPS:      rd_data = CAPS_WORD;
            default: begin
                if (address[3] && (32'(user_idx) < NUM_USER)) begin
                    rd_data = user_words[{user_idx, 5'd0} +: 32];
                end
            end
        endcase
    end

    // Read samples pre-write state, so a same-cycle read/write returns the old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch_q  <= '0;
            readdata_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            if (scratch_we) begin
                scratch_q <= writedata;
            end
            rvalid_q <= read;
            if (read) begin
                readdata_q <= rd_data;
            end
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rvalid_q;

endmodule

// File: doc/sysid_regs_ext.md
# sysid_regs_ext

Parametrised successor to the single-word SOPC system-ID slave: an Avalon-MM register block exposing system ID, build timestamp, a capability word, a read/write scratch register, an optional 64-bit uptime counter with atomic high-word capture, and up to 8 user-supplied ID words. It sits on the Nios II data master's peripheral bus. Boot software uses it to identify the image, test the bus and measure elapsed time.

## Interface
- SYSTEM_ID, 32'h0000_0000: constant returned at word 0.
- TIMESTAMP, 32'h0000_0000: build time (Unix seconds) returned at word 1.
- NUM_USER, 2: number of user ID words, range 0..8.
- ADDR_W, 4: word-address width, fixed at 4 (16 words).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, single cycle.
- write  in  1  write strobe, single cycle.
- writedata  in  32  write data.
- user_words  in  32*8  user ID words. Word k is bits [32k+31:32k]. Each word must be static or quasi-static.
- readdata  out  32  registered read data.
- readdatavalid  out  1  read response strobe.

## Operation
- Register map (word address):
  - 0: ID (RO).
  - 1: TIMESTAMP (RO).
  - 2: UPTIME_LO (RO).
  - 3: UPTIME_HI shadow (RO).
  - 4: SCRATCH (RW).
  - 5: CONTROL (WO, reads 0).
  - 6: CAPS (RO).
  - 7: reserved, reads 0.
  - 8..15: USER[k] (RO) for k < NUM_USER. Reads 0 for k >= NUM_USER.
- CAPS fields:
  - [3:0] NUM_USER.
  - [8] uptime present.
  - [31:16] version, 16'h0002.
- Uptime counter:
  - 64 bits, increments by 1 every clock.
  - Wraps from 2^64-1 to 0 with no flag.
- Atomic read of the uptime value:
  - A read of UPTIME_LO returns counter[31:0] as sampled in the read cycle.
  - In the same cycle, counter[63:32] is copied into the HI shadow.
  - A read of UPTIME_HI returns the shadow and does not modify it.
  - Software reads LO first, then HI.
- CONTROL[0] = 1 (clear): the counter is 0 in the cycle after the write. The HI shadow is unchanged. Other CONTROL bits are ignored.
- Writes to RO or unmapped addresses are ignored.
- read and write asserted in the same cycle:
  - The write takes effect.
  - The read returns pre-write values.

## Timing
- No waitrequest. Every read or write is accepted in the cycle it is asserted.
- Fixed read latency of 1:
  - A read in cycle t gives readdatavalid = 1 and valid readdata in cycle t+1.
  - Back-to-back reads give one response per cycle.
- readdata holds its last value when readdatavalid = 0.
- Values on reset assertion:
  - readdata = 0, readdatavalid = 0.
  - SCRATCH = 0, uptime = 0, HI shadow = 0.
- Reset asserted mid-operation: a pending response is dropped, so no readdatavalid follows.
- After reset deasserts, the counter reads 0 in the first clock edge's cycle, then increments.
- Clear versus read of UPTIME_LO in the same cycle:
  - The read returns the pre-clear value and captures the pre-clear HI.
  - The counter is 0 in the next cycle.

## Configuration
- SYSID_UPTIME_EN defined: the counter, HI shadow and CONTROL clear are built in, and CAPS[8] = 1.
- SYSID_UPTIME_EN undefined:
  - No counter flops.
  - Words 2 and 3 read 0.
  - CONTROL writes are ignored.
  - CAPS[8] = 0.

## Structure
- Shared package sysid_pkg holds:
  - Register address localparams (SYSID_ADDR_ID through SYSID_ADDR_USER0).
  - CAPS version constant.
  - CAPS bit positions.
  - CONTROL clear bit index.
- One sub-module, sysid_uptime_ctr: the 64-bit counter, clear input, capture input and HI shadow output. It is instantiated only under SYSID_UPTIME_EN.
- The top level contains the read mux, the SCRATCH flop and the response pipeline flop.

## Test plan
- Reset then read words 0, 1, 6 back-to-back with SYSTEM_ID = 32'h1234_5678, TIMESTAMP = 32'h4C00_0000, NUM_USER = 2:
  - Responses 32'h1234_5678, 32'h4C00_0000, 32'h0002_0102.
  - readdatavalid high for 3 consecutive cycles, starting 1 cycle after the first read.
- Write SCRATCH = 32'hDEAD_BEEF, then read word 4 → 32'hDEAD_BEEF. Assert reset, then read word 4 → 0.
- Force the counter to 64'h0000_0000_FFFF_FFFE via clear plus elapsed cycles. Read LO in a cycle where the counter is 64'h0000_0000_FFFF_FFFF, wait 5 cycles, then read HI:
  - LO = 32'hFFFF_FFFF.
  - HI = 0 (the shadow, not the live value 1).
- Write CONTROL = 1 and read UPTIME_LO in the same cycle:
  - The read returns the pre-clear value.
  - A read of LO 3 cycles later returns 2.
- user_words word 0 = 32'hA5A5_0001, word 1 = 32'hA5A5_0002, word 2 = 32'h1111_1111, with NUM_USER = 2:
  - Words 8 and 9 return 32'hA5A5_0001 and 32'hA5A5_0002.
  - Word 10 returns 0 despite its nonzero input.
  - Word 7 returns 0.
- Build without SYSID_UPTIME_EN:
  - Words 2 and 3 read 0.
  - CAPS[8] = 0.
  - A CONTROL write has no effect.
